// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side controller for the dual-clock asynchronous FIFO
//
// Purpose: tracks the write pointer in binary and Gray form, drives the RAM
// write port, synchronizes the read pointer into wclk and derives full,
// almost-full, occupancy level and a sticky overflow flag.
//
// Ports:
//   wclk          write-domain clock
//   wrst          asynchronous active-low reset
//   winc          producer write request
//   wclr_ovf      synchronous clear of woverflow
//   rptr          Gray read pointer from the rclk domain (unsynchronized)
//   wen           RAM write enable (winc & ~wfull)
//   waddr         RAM write address
//   wptr          registered Gray write pointer, to the read side
//   wfull         registered full flag
//   walmost_full  wlevel >= AF_THRESH
//   wlevel        occupancy seen from the write domain, 0..DEPTH
//   woverflow     sticky: write attempted while full

module fifo_wr_ctrl #(
   parameter int DEPTH       = 8,
   parameter int AF_THRESH   = DEPTH - 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       wclk,
   input  logic                       wrst,
   input  logic                       winc,
   input  logic                       wclr_ovf,
   input  logic [$clog2(DEPTH):0]     rptr,
   output logic                       wen,
   output logic [$clog2(DEPTH)-1:0]   waddr,
   output logic [$clog2(DEPTH):0]     wptr,
   output logic                       wfull,
   output logic                       walmost_full,
   output logic [$clog2(DEPTH):0]     wlevel,
   output logic                       woverflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);

   logic [AW:0]                   wbin;
   logic [AW:0]                   wbin_next;
   logic [AW:0]                   wgray_next;
   logic [SYNC_STAGES-1:0][AW:0]  sync_q;
   logic [AW:0]                   rq;
   logic [AW:0]                   rq_bin;
   logic                          full_next;

   assign rq = sync_q[SYNC_STAGES-1];

   // Read pointer enters wclk only through this flop chain.
   always_ff @(posedge wclk or negedge wrst) begin
      if (!wrst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rptr};
      end
   end

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rq_bin = '0;
      for (int i = 0; i <= AW; i++) begin
         rq_bin[i] = ^(rq >> i);
      end
   end

   assign wen        = winc & ~wfull;
   assign waddr      = wbin[AW-1:0];
   assign wbin_next  = wbin + {{AW{1'b0}}, wen};
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;

   // Full when the next write pointer has lapped the read pointer by one
   // full turn: top two Gray bits inverted, the rest equal.
   assign full_next = (wgray_next == {~rq[AW], ~rq[AW-1], rq[AW-2:0]});

   always_ff @(posedge wclk or negedge wrst) begin
      if (!wrst) begin
         wbin      <= '0;
         wptr      <= '0;
         wfull     <= 1'b0;
         woverflow <= 1'b0;
      end else begin
         wbin  <= wbin_next;
         wptr  <= wgray_next;
         wfull <= full_next;
         // A fresh overflow wins over a clear in the same cycle.
         if (winc & wfull) begin
            woverflow <= 1'b1;
         end else if (wclr_ovf) begin
            woverflow <= 1'b0;
         end
      end
   end

   // The synchronized read pointer is stale, so the level only overestimates.
   assign wlevel       = wbin - rq_bin;
   assign walmost_full = (wlevel >= AF_LVL);

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl (DEPTH=8, AF_THRESH=6, SYNC_STAGES=2)

module tb_fifo_wr_ctrl;

   logic       wclk = 1'b0;
   logic       wrst;
   logic       winc;
   logic       wclr_ovf;
   logic [3:0] rptr;
   logic       wen;
   logic [2:0] waddr;
   logic [3:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [3:0] wlevel;
   logic       woverflow;

   typedef struct packed {
      logic [2:0] addr;
      logic [3:0] ptr;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_pass   = 0;

   fifo_wr_ctrl #(.DEPTH(8), .AF_THRESH(6), .SYNC_STAGES(2)) dut (
      .wclk(wclk), .wrst(wrst), .winc(winc), .wclr_ovf(wclr_ovf), .rptr(rptr),
      .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
      .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
   );

   always #5 wclk = ~wclk;

   function automatic logic [3:0] gray(input int b);
      logic [3:0] x;
      x = b[3:0];
      return x ^ (x >> 1);
   endfunction

   task automatic test_reset();
      wrst = 1'b0; winc = 1'b1; wclr_ovf = 1'b0; rptr = 4'b0000;
      #12;
      n_checks++; if (wptr !== 4'b0000) $display("FAIL rst_wptr got %b exp 0000", wptr); else n_pass++;
      n_checks++; if (waddr !== 3'd0) $display("FAIL rst_waddr got %0d exp 0", waddr); else n_pass++;
      n_checks++; if (wfull !== 1'b0) $display("FAIL rst_wfull got %b exp 0", wfull); else n_pass++;
      n_checks++; if (wlevel !== 4'd0) $display("FAIL rst_wlevel got %0d exp 0", wlevel); else n_pass++;
      n_checks++; if (woverflow !== 1'b0) $display("FAIL rst_wovf got %b exp 0", woverflow); else n_pass++;
      n_checks++; if (walmost_full !== 1'b0) $display("FAIL rst_waf got %b exp 0", walmost_full); else n_pass++;
      winc = 1'b0;
      #1 wrst = 1'b1;
      @(negedge wclk);
      n_checks++; if (wen !== 1'b0) $display("FAIL rst_wen got %b exp 0", wen); else n_pass++;
      @(posedge wclk); #1;
      n_checks++; if (wptr !== 4'b0000) $display("FAIL rst_idle_wptr got %b exp 0000", wptr); else n_pass++;
   endtask

   task automatic test_fill();
      logic [3:0] seq [8];
      seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      rptr = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         sb.push_back(exp_t'{addr: 3'(i), ptr: seq[i]});
         winc = 1'b1;
         @(negedge wclk);
         e = sb.pop_front();
         n_checks++; if (wen !== 1'b1) $display("FAIL fill_wen[%0d] got %b exp 1", i, wen); else n_pass++;
         n_checks++; if (waddr !== e.addr) $display("FAIL fill_waddr[%0d] got %0d exp %0d", i, waddr, e.addr); else n_pass++;
         @(posedge wclk); #1;
         n_checks++; if (wptr !== e.ptr) $display("FAIL fill_wptr[%0d] got %b exp %b", i, wptr, e.ptr); else n_pass++;
         n_checks++; if (wlevel !== 4'(i + 1)) $display("FAIL fill_wlevel[%0d] got %0d exp %0d", i, wlevel, i + 1); else n_pass++;
         n_checks++; if (walmost_full !== (i + 1 >= 6)) $display("FAIL fill_waf[%0d] got %b exp %b", i, walmost_full, (i + 1 >= 6)); else n_pass++;
         n_checks++; if (wfull !== (i == 7)) $display("FAIL fill_wfull[%0d] got %b exp %b", i, wfull, (i == 7)); else n_pass++;
      end
      winc = 1'b0;
   endtask

   task automatic test_overflow();
      winc = 1'b1;
      @(negedge wclk);
      n_checks++; if (wen !== 1'b0) $display("FAIL ovf_wen got %b exp 0", wen); else n_pass++;
      @(posedge wclk); #1;
      n_checks++; if (wptr !== 4'b1100) $display("FAIL ovf_wptr got %b exp 1100", wptr); else n_pass++;
      n_checks++; if (woverflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", woverflow); else n_pass++;
      wclr_ovf = 1'b1;
      @(posedge wclk); #1;
      n_checks++; if (woverflow !== 1'b1) $display("FAIL ovf_priority got %b exp 1", woverflow); else n_pass++;
      winc = 1'b0;
      @(posedge wclk); #1;
      n_checks++; if (woverflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", woverflow); else n_pass++;
      wclr_ovf = 1'b0;
   endtask

   task automatic test_drain();
      rptr = 4'b0011;
      @(posedge wclk); #1;
      n_checks++; if (wfull !== 1'b1) $display("FAIL drain_full_e1 got %b exp 1", wfull); else n_pass++;
      @(posedge wclk); #1;
      n_checks++; if (wfull !== 1'b1) $display("FAIL drain_full_e2 got %b exp 1", wfull); else n_pass++;
      @(posedge wclk); #1;
      n_checks++; if (wfull !== 1'b0) $display("FAIL drain_full_e3 got %b exp 0", wfull); else n_pass++;
      n_checks++; if (wlevel !== 4'd6) $display("FAIL drain_wlevel6 got %0d exp 6", wlevel); else n_pass++;
      n_checks++; if (walmost_full !== 1'b1) $display("FAIL drain_waf6 got %b exp 1", walmost_full); else n_pass++;
      rptr = 4'b0110;
      @(posedge wclk); @(posedge wclk); #1;
      n_checks++; if (wlevel !== 4'd4) $display("FAIL drain_wlevel4 got %0d exp 4", wlevel); else n_pass++;
      n_checks++; if (walmost_full !== 1'b0) $display("FAIL drain_waf4 got %b exp 0", walmost_full); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [3:0] prev;
      bit seen_wrap = 0;
      wrst = 1'b0; rptr = 4'b0000;
      #1 wrst = 1'b1;
      for (int cnt = 0; cnt < 20; cnt++) begin
         rptr = (cnt >= 2) ? gray(cnt - 2) : 4'b0000;
         sb.push_back(exp_t'{addr: 3'(cnt % 8), ptr: gray(cnt + 1)});
         prev = wptr;
         winc = 1'b1;
         @(negedge wclk);
         e = sb.pop_front();
         n_checks++; if (wen !== 1'b1) $display("FAIL wrap_wen[%0d] got %b exp 1", cnt, wen); else n_pass++;
         n_checks++; if (waddr !== e.addr) $display("FAIL wrap_waddr[%0d] got %0d exp %0d", cnt, waddr, e.addr); else n_pass++;
         @(posedge wclk); #1;
         n_checks++; if (wptr !== e.ptr) $display("FAIL wrap_wptr[%0d] got %b exp %b", cnt, wptr, e.ptr); else n_pass++;
         n_checks++; if ($countones(wptr ^ prev) != 1) $display("FAIL wrap_onebit[%0d] got %b->%b exp one bit change", cnt, prev, wptr); else n_pass++;
         n_checks++; if (wfull !== 1'b0) $display("FAIL wrap_wfull[%0d] got %b exp 0", cnt, wfull); else n_pass++;
         if (prev == 4'b1000 && wptr == 4'b0000) seen_wrap = 1;
      end
      winc = 1'b0;
      n_checks++; if (!seen_wrap) $display("FAIL wrap_seen got 0 exp 1"); else n_pass++;
   endtask

   task automatic test_async_reset();
      wrst = 1'b0; rptr = 4'b0000;
      #1 wrst = 1'b1;
      winc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge wclk); #1;
      end
      winc = 1'b0;
      n_checks++; if (wlevel !== 4'd5) $display("FAIL arst_pre_level got %0d exp 5", wlevel); else n_pass++;
      #1 wrst = 1'b0;
      #1;
      n_checks++; if (wptr !== 4'b0000) $display("FAIL arst_wptr got %b exp 0000", wptr); else n_pass++;
      n_checks++; if (waddr !== 3'd0) $display("FAIL arst_waddr got %0d exp 0", waddr); else n_pass++;
      n_checks++; if (wlevel !== 4'd0) $display("FAIL arst_wlevel got %0d exp 0", wlevel); else n_pass++;
      n_checks++; if (wfull !== 1'b0) $display("FAIL arst_wfull got %b exp 0", wfull); else n_pass++;
      n_checks++; if (woverflow !== 1'b0) $display("FAIL arst_wovf got %b exp 0", woverflow); else n_pass++;
      #1 wrst = 1'b1;
      sb.push_back(exp_t'{addr: 3'd0, ptr: 4'b0001});
      winc = 1'b1;
      @(negedge wclk);
      e = sb.pop_front();
      n_checks++; if (wen !== 1'b1) $display("FAIL arst_next_wen got %b exp 1", wen); else n_pass++;
      n_checks++; if (waddr !== e.addr) $display("FAIL arst_next_waddr got %0d exp %0d", waddr, e.addr); else n_pass++;
      @(posedge wclk); #1;
      n_checks++; if (wptr !== e.ptr) $display("FAIL arst_next_wptr got %b exp %b", wptr, e.ptr); else n_pass++;
      winc = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_async_reset();
      n_checks++; if (sb.size() != 0) $display("FAIL sb_empty got %0d exp 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
